deser_12: RTL and testbench

DESER_12 -- requirements
Module: deser_12

---
 rtl/deser_12.sv | 151 +++++++++++++++
 tb/tb_deser_12.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deser_12.sv
`default_nettype none
// ============================================================================
// Module  : deser_12
// Brief   : 12-bit DDR ADC deserializer, word-framed by adc_clk_x2.
//           Optional adc_clk_x4-gated output stage: DESER_12_OUT_REG_EN.
// Revision: 1.0
// ============================================================================
module deser_12 #(
    parameter int FRAME_OFFSET = 1
) (
    input  logic        dclk_p,
    input  logic        dclk_n,
    input  logic        rst,
    input  logic        adc_clk_x4,
    input  logic        adc_clk_x2,
    input  logic        data_in,
    output logic [11:0] data_out
);

    localparam logic [2:0] C_LAST_PAIR = 3'd5;

    logic        r_cap_p;
    logic        r_cap_n;
    logic [11:0] r_shift;
    logic [2:0]  r_x2_sync;
    logic [1:0]  r_x4_sync;
    logic [2:0]  r_primed;
    logic [2:0]  r_pair_cnt;
    logic        r_aligned;
    logic        w_frame_start;
    logic        w_force;
    logic        w_wrap;
    logic        w_transfer;

    // DDR capture: the dclk_p bit is the earlier (more significant) bit of the pair
    always_ff @(posedge dclk_p) begin
        if (!rst) begin
            r_cap_p <= 1'b0;
        end else begin
            r_cap_p <= data_in;
        end
    end

    always_ff @(posedge dclk_n) begin
        if (!rst) begin
            r_cap_n <= 1'b0;
        end else begin
            r_cap_n <= data_in;
        end
    end

    always_ff @(posedge dclk_p) begin
        if (!rst) begin
            r_shift <= 12'h000;
        end else begin
            r_shift <= {r_shift[9:0], r_cap_p, r_cap_n};
        end
    end

    // r_x2_sync[2] only serves edge detection; r_primed masks the edge until
    // all three stages hold post-reset samples, so a high frame clock at
    // reset release is not mistaken for a frame start.
    always_ff @(posedge dclk_p) begin
        if (!rst) begin
            r_x2_sync <= 3'b000;
            r_x4_sync <= 2'b00;
            r_primed  <= 3'b000;
        end else begin
            r_x2_sync <= {r_x2_sync[1:0], adc_clk_x2};
            r_x4_sync <= {r_x4_sync[0], adc_clk_x4};
            r_primed  <= {r_primed[1:0], 1'b1};
        end
    end

    assign w_frame_start = r_primed[2] & r_x2_sync[1] & ~r_x2_sync[2];

    // w_force lands on the edge where the [11:10] pair enters r_shift
    generate
        if (FRAME_OFFSET <= 1) begin : g_offset_direct
            assign w_force = w_frame_start;
        end else begin : g_offset_delay
            logic [FRAME_OFFSET-2:0] r_fs_dly;
            always_ff @(posedge dclk_p) begin
                if (!rst) begin
                    r_fs_dly <= '0;
                end else begin
                    r_fs_dly[0] <= w_frame_start;
                    for (int i = 1; i < FRAME_OFFSET - 1; i++) begin
                        r_fs_dly[i] <= r_fs_dly[i-1];
                    end
                end
            end
            assign w_force = r_fs_dly[FRAME_OFFSET-2];
        end
    endgenerate

    assign w_wrap     = (r_pair_cnt == C_LAST_PAIR);
    assign w_transfer = w_wrap & r_aligned;

    // A force away from the wrap point restarts the count; no transfer, so the
    // partial word simply shifts out.
    always_ff @(posedge dclk_p) begin
        if (!rst) begin
            r_pair_cnt <= 3'd0;
            r_aligned  <= 1'b0;
        end else begin
            if (w_force) begin
                r_pair_cnt <= 3'd0;
                r_aligned  <= 1'b1;
            end else if (w_wrap) begin
                r_pair_cnt <= 3'd0;
            end else begin
                r_pair_cnt <= r_pair_cnt + 3'd1;
            end
        end
    end

`ifdef DESER_12_OUT_REG_EN
    logic [11:0] r_stage;
    logic        r_stage_upd;

    always_ff @(posedge dclk_p) begin
        if (!rst) begin
            r_stage     <= 12'h000;
            r_stage_upd <= 1'b0;
            data_out    <= 12'h000;
        end else begin
            r_stage_upd <= w_transfer & r_x4_sync[1];
            if (w_transfer) begin
                r_stage <= r_shift;
            end
            if (r_stage_upd) begin
                data_out <= r_stage;
            end
        end
    end
`else
    logic w_unused_x4;
    assign w_unused_x4 = r_x4_sync[1];

    always_ff @(posedge dclk_p) begin
        if (!rst) begin
            data_out <= 12'h000;
        end else if (w_transfer) begin
            data_out <= r_shift;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_deser_12.sv
`default_nettype none
// Bench for deser_12: random/patterned DDR pair streams against a stream-level
// word model (frame starts, 6-pair words, fixed output latency).
module tb_deser_12;

    localparam int FRAME_OFFSET = 1;
`ifdef DESER_12_OUT_REG_EN
    localparam int LAT     = 3;
    localparam bit GATE_X4 = 1'b1;
`else
    localparam int LAT     = 2;
    localparam bit GATE_X4 = 1'b0;
`endif

    logic        dclk_p = 1'b0;
    logic        dclk_n;
    logic        rst;
    logic        adc_clk_x4;
    logic        adc_clk_x2;
    logic        data_in;
    logic [11:0] data_out;

    assign dclk_n = ~dclk_p;
    always #10 dclk_p = ~dclk_p;

    deser_12 #(.FRAME_OFFSET(FRAME_OFFSET)) dut (
        .dclk_p     (dclk_p),
        .dclk_n     (dclk_n),
        .rst        (rst),
        .adc_clk_x4 (adc_clk_x4),
        .adc_clk_x2 (adc_clk_x2),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [1:0]  pair_hist [0:4095];
    logic [11:0] exp_out  = 12'h000;
    int          last_rst = 0;
    logic        prev_x2  = 1'b0;
    bit          aligned  = 1'b0;
    int          start    = 0;
    int          due_q[$];
    logic [11:0] val_q[$];
    int          msb_q[$];

    function automatic logic [1:0] wpair(input logic [11:0] w, input int p);
        return w[11-2*p -: 2];
    endfunction

    // frame clock high for pairs 5,0,1: rises one pair ahead of the MSB pair
    function automatic logic fx2(input int p);
        return (p == 0) || (p == 1) || (p == 5);
    endfunction

    function automatic logic [1:0] fx4(input int p);
        logic a;
        logic b;
        a = (((2*p + 3) % 6) < 3);
        b = (((2*p + 4) % 6) < 3);
        return {a, b};
    endfunction

    function automatic logic [1:0] rnd2();
        return 2'($urandom_range(3));
    endfunction

    // One dclk_p period: bit A around the rise, bit B around dclk_n's rise.
    // Returns 5 ns after the rise with exp_out updated for that rise.
    task automatic send_pair(input logic [1:0] pr, input logic x2,
                             input logic [1:0] x4, input logic rst_v);
        logic [11:0] w;
        #10;
        cyc++;
        rst        = rst_v;
        data_in    = pr[1];
        adc_clk_x2 = x2;
        adc_clk_x4 = x4[1];
        #10;
        data_in    = pr[0];
        adc_clk_x4 = x4[0];
        pair_hist[cyc] = pr;
        if (!rst_v) begin
            exp_out  = 12'h000;
            aligned  = 1'b0;
            last_rst = cyc;
            due_q.delete();
            val_q.delete();
            msb_q.delete();
        end else begin
            while (due_q.size() > 0 && due_q[0] == cyc) begin
                exp_out = val_q[0];
                void'(due_q.pop_front());
                void'(val_q.pop_front());
            end
            if (x2 && !prev_x2 && (cyc - 1 > last_rst))
                msb_q.push_back(cyc + FRAME_OFFSET);
            if (msb_q.size() > 0 && msb_q[0] == cyc) begin
                start   = cyc;
                aligned = 1'b1;
                void'(msb_q.pop_front());
            end
            if (aligned && ((cyc - start) % 6) == 5) begin
                w = 12'h000;
                for (int i = 0; i < 6; i++) w = {w[9:0], pair_hist[cyc-5+i]};
                if (!GATE_X4 || x4[1]) begin
                    due_q.push_back(cyc + LAT);
                    val_q.push_back(w);
                end
            end
        end
        prev_x2 = x2;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            send_pair(rnd2(), 1'b0, rnd2(), 1'b0);
            checks++;
            if (data_out !== 12'h000) begin
                errors++;
                $display("FAIL reset cyc=%0d data_out=%03h expected=000", cyc, data_out);
            end
        end
        for (int i = 0; i < 4; i++) begin
            send_pair(rnd2(), 1'b0, rnd2(), 1'b1);
            checks++;
            if (data_out !== 12'h000) begin
                errors++;
                $display("FAIL idle cyc=%0d data_out=%03h expected=000", cyc, data_out);
            end
        end
    endtask

    task automatic test_rotating();
        logic [11:0] words [3];
        words = '{12'h004, 12'h002, 12'h001};
        send_pair(rnd2(), 1'b1, fx4(5), 1'b1);
        checks++;
        if (data_out !== 12'h000) begin
            errors++;
            $display("FAIL leadin cyc=%0d data_out=%03h expected=000", cyc, data_out);
        end
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 3; n++) begin
                for (int p = 0; p < 6; p++) begin
                    send_pair(wpair(words[n], p), fx2(p), fx4(p), 1'b1);
                    checks++;
                    if (data_out !== exp_out) begin
                        errors++;
                        $display("FAIL rotating cyc=%0d data_out=%03h expected=%03h",
                                 cyc, data_out, exp_out);
                    end
                end
            end
        end
    endtask

    task automatic test_walking();
        logic [11:0] words [3];
        words = '{12'h800, 12'h555, 12'h000};
        for (int n = 0; n < 3; n++) begin
            for (int p = 0; p < 6; p++) begin
                send_pair(wpair(words[n], p), fx2(p), fx4(p), 1'b1);
                checks++;
                if (data_out !== exp_out) begin
                    errors++;
                    $display("FAIL walking cyc=%0d data_out=%03h expected=%03h",
                             cyc, data_out, exp_out);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] w;
        for (int n = 0; n < 8; n++) begin
            w = 12'($urandom);
            for (int p = 0; p < 6; p++) begin
                send_pair(wpair(w, p), fx2(p), rnd2(), 1'b1);
                checks++;
                if (data_out !== exp_out) begin
                    errors++;
                    $display("FAIL random cyc=%0d data_out=%03h expected=%03h",
                             cyc, data_out, exp_out);
                end
            end
        end
    endtask

    // frame clock parked high: the last alignment keeps framing words
    task automatic test_static_x2();
        logic [11:0] w;
        for (int n = 0; n < 4; n++) begin
            w = 12'($urandom);
            for (int p = 0; p < 6; p++) begin
                send_pair(wpair(w, p), (n < 3) ? 1'b1 : fx2(p), fx4(p), 1'b1);
                checks++;
                if (data_out !== exp_out) begin
                    errors++;
                    $display("FAIL static_x2 cyc=%0d data_out=%03h expected=%03h",
                             cyc, data_out, exp_out);
                end
            end
        end
    endtask

    // a 4-pair frame advances the frame clock phase by 2 pairs
    task automatic test_realign();
        logic [11:0] w;
        logic [3:0]  trunc_x2;
        trunc_x2 = 4'b1011;
        w = 12'($urandom);
        for (int p = 0; p < 6; p++) begin
            send_pair(wpair(w, p), fx2(p), fx4(p), 1'b1);
            checks++;
            if (data_out !== exp_out) begin
                errors++;
                $display("FAIL realign cyc=%0d data_out=%03h expected=%03h",
                         cyc, data_out, exp_out);
            end
        end
        w = 12'($urandom);
        for (int p = 0; p < 4; p++) begin
            send_pair(wpair(w, p), trunc_x2[p], fx4(p), 1'b1);
            checks++;
            if (data_out !== exp_out) begin
                errors++;
                $display("FAIL realign cyc=%0d data_out=%03h expected=%03h",
                         cyc, data_out, exp_out);
            end
        end
        for (int n = 0; n < 3; n++) begin
            w = 12'($urandom);
            for (int p = 0; p < 6; p++) begin
                send_pair(wpair(w, p), fx2(p), fx4(p), 1'b1);
                checks++;
                if (data_out !== exp_out) begin
                    errors++;
                    $display("FAIL realign cyc=%0d data_out=%03h expected=%03h",
                             cyc, data_out, exp_out);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] w;
        for (int n = 0; n < 4; n++) begin
            w = 12'($urandom);
            for (int p = 0; p < 6; p++) begin
                send_pair(wpair(w, p), fx2(p), fx4(p), !(n == 1 && p == 3));
                checks++;
                if (data_out !== exp_out) begin
                    errors++;
                    $display("FAIL reset_mid cyc=%0d data_out=%03h expected=%03h",
                             cyc, data_out, exp_out);
                end
            end
        end
    endtask

    task automatic test_x4_gate();
        logic [11:0] w;
        for (int n = 0; n < 7; n++) begin
            w = 12'($urandom);
            for (int p = 0; p < 6; p++) begin
                send_pair(wpair(w, p), fx2(p), (n < 3) ? 2'b00 : fx4(p), 1'b1);
                checks++;
                if (data_out !== exp_out) begin
                    errors++;
                    $display("FAIL x4_gate cyc=%0d data_out=%03h expected=%03h",
                             cyc, data_out, exp_out);
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        data_in    = 1'b0;
        adc_clk_x2 = 1'b0;
        adc_clk_x4 = 1'b0;
        #15;
        test_reset();
        test_rotating();
        test_walking();
        test_random();
        test_static_x2();
        test_realign();
        test_reset_mid();
        test_x4_gate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
